// File: rtl/gf180mcu_osu_sc_9t_ro_meas_if.sv
// Control/result bundle of the ring-oscillator measurement stage.
// The master requests a window; the slave reports busy/done and the edge count.
interface gf180mcu_osu_sc_9t_ro_meas_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 12
);
    logic             en;
    logic             start;
    logic [WIN_W-1:0] win_cyc;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (output en, start, win_cyc, input busy, done, count, ovf);
    modport slave  (input en, start, win_cyc, output busy, done, count, ovf);
endinterface

// File: rtl/gf180mcu_osu_sc_9t_ro_meas.sv
// Counts synchronized rising edges of a ring-oscillator output over a
// programmable window of reference-clock cycles, with start/done handshake.
module gf180mcu_osu_sc_9t_ro_meas #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rn,
    input  logic i_ro_in,
    gf180mcu_osu_sc_9t_ro_meas_if.slave s_bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MEASURE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic             r_prev;
    logic             w_edge;
    logic [WIN_W-1:0] r_win, w_win_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_sat, w_sat_nxt, w_sat_inc;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_ovf, w_ovf_nxt;

    // RO_IN is asynchronous; the edge detector runs every cycle so a level
    // already high when a window opens is never counted as an edge.
    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ro_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    always_comb begin
        w_cnt_inc = r_cnt;
        w_sat_inc = r_sat;
        if (w_edge) begin
            if (r_cnt == CNT_MAX) begin
                w_sat_inc = 1'b1;
            end else begin
                w_cnt_inc = r_cnt + CNT_ONE;
            end
        end else begin
            w_cnt_inc = r_cnt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) begin
            r_win   <= WIN_ZERO;
            r_cnt   <= CNT_ZERO;
            r_sat   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= CNT_ZERO;
            r_ovf   <= 1'b0;
        end else begin
            r_win   <= w_win_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // The final window cycle publishes the count including that cycle's edge.
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_cnt_nxt   = r_cnt;
        w_sat_nxt   = r_sat;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        if (!s_bus.en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_bus.start) begin
                        if (s_bus.win_cyc != WIN_ZERO) begin
                            w_state_nxt = ST_MEASURE;
                            w_win_nxt   = s_bus.win_cyc;
                            w_cnt_nxt   = CNT_ZERO;
                            w_sat_nxt   = 1'b0;
                            w_busy_nxt  = 1'b1;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_count_nxt = CNT_ZERO;
                            w_ovf_nxt   = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    w_win_nxt = r_win - WIN_ONE;
                    w_cnt_nxt = w_cnt_inc;
                    w_sat_nxt = w_sat_inc;
                    if (r_win == WIN_ONE) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_count_nxt = w_cnt_inc;
                        w_ovf_nxt   = w_sat_inc;
                    end else begin
                        w_busy_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign s_bus.busy  = r_busy;
    assign s_bus.done  = r_done;
    assign s_bus.count = r_count;
    assign s_bus.ovf   = r_ovf;
endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_ro_meas.sv
// Scoreboard bench for the ring-oscillator measurement stage: expected results
// are queued when a window is requested and checked when DONE appears.
module tb_gf180mcu_osu_sc_9t_ro_meas;
    logic clk = 1'b0;
    logic rn  = 1'b0;
    logic ro  = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gf180mcu_osu_sc_9t_ro_meas_if #(.CNT_W(16), .WIN_W(12)) b16 ();
    gf180mcu_osu_sc_9t_ro_meas_if #(.CNT_W(4),  .WIN_W(12)) b4 ();

    gf180mcu_osu_sc_9t_ro_meas #(.CNT_W(16), .WIN_W(12), .SYNC_STAGES(2)) dut16 (
        .i_clk(clk), .i_rn(rn), .i_ro_in(ro), .s_bus(b16));
    gf180mcu_osu_sc_9t_ro_meas #(.CNT_W(4), .WIN_W(12), .SYNC_STAGES(2)) dut4 (
        .i_clk(clk), .i_rn(rn), .i_ro_in(ro), .s_bus(b4));

    typedef struct {int cnt; int ovf; int at;} exp_t;
    exp_t q16[$];
    exp_t q4[$];
    exp_t m_e;
    int checks = 0;
    int errors = 0;
    int last16_cnt = 0;
    int last16_ovf = 0;

    // RO level sampled at edge k+p, p relative to the START-accepting edge k
    function automatic bit ro_at(input int mode, input int p);
        case (mode)
            0:       return (p >= 10) && (((p - 10) % 4) < 2);
            1:       return (p >= 1) && ((p % 2) == 1);
            default: return 1'b1;
        endcase
    endfunction

    // A rise sampled at k+p is counted at edge k+p+2, which must lie in k+1..k+w
    function automatic int model_edges(input int mode, input int w);
        int n;
        n = 0;
        for (int p = -1; p <= w - 2; p++) begin
            if (ro_at(mode, p) && !ro_at(mode, p - 1)) n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (b16.done) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done16 cyc=%0d count=%0d", cyc, b16.count);
            end else begin
                m_e = q16.pop_front();
                if (b16.count !== m_e.cnt[15:0] || b16.ovf !== m_e.ovf[0] || cyc != m_e.at) begin
                    errors++;
                    $display("FAIL done16 got count=%0d ovf=%0d cyc=%0d want count=%0d ovf=%0d cyc=%0d",
                             b16.count, b16.ovf, cyc, m_e.cnt, m_e.ovf, m_e.at);
                end
                last16_cnt = m_e.cnt;
                last16_ovf = m_e.ovf;
            end
        end
        if (b4.done) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done4 cyc=%0d count=%0d", cyc, b4.count);
            end else begin
                m_e = q4.pop_front();
                if (b4.count !== m_e.cnt[3:0] || b4.ovf !== m_e.ovf[0] || cyc != m_e.at) begin
                    errors++;
                    $display("FAIL done4 got count=%0d ovf=%0d cyc=%0d want count=%0d ovf=%0d cyc=%0d",
                             b4.count, b4.ovf, cyc, m_e.cnt, m_e.ovf, m_e.at);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        ro = 1'b0;
        repeat (6) step();
    endtask

    task automatic run(input int dut, input int w, input int mode, input int len, input bit push,
                       input int pulse_at, input int drop_at, output int nbusy);
        int   k, n, maxv;
        exp_t e;
        k      = cyc + 1;
        n      = model_edges(mode, w);
        maxv   = (dut == 4) ? 15 : 65535;
        e.cnt  = (n > maxv) ? maxv : n;
        e.ovf  = (n > maxv) ? 1 : 0;
        e.at   = k + w;
        if (push) begin
            if (dut == 4) q4.push_back(e);
            else          q16.push_back(e);
        end
        if (dut == 4) begin
            b4.start = 1'b1;  b4.win_cyc = w[11:0];
        end else begin
            b16.start = 1'b1; b16.win_cyc = w[11:0];
        end
        ro = ro_at(mode, 0);
        step();
        nbusy = 0;
        if ((dut == 4) ? b4.busy : b16.busy) nbusy++;
        b4.start  = 1'b0;
        b16.start = 1'b0;
        for (int i = 1; i <= len; i++) begin
            ro = ro_at(mode, i);
            if (i == pulse_at) begin
                b16.start = 1'b1; b16.win_cyc = 12'd3;
            end else begin
                b16.start = 1'b0;
            end
            if (i == drop_at) b16.en = 1'b0;
            step();
            if ((dut == 4) ? b4.busy : b16.busy) nbusy++;
        end
        b16.start = 1'b0;
        ro = 1'b0;
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk_drained(input string name);
        checks++;
        if (q16.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL %s missing_done pending16=%0d pending4=%0d", name, q16.size(), q4.size());
            q16.delete();
            q4.delete();
        end
    endtask

    task automatic test_reset();
        rn = 1'b0; ro = 1'b0;
        b16.en = 1'b1; b16.start = 1'b0; b16.win_cyc = 12'd0;
        b4.en  = 1'b1; b4.start  = 1'b0; b4.win_cyc  = 12'd0;
        repeat (3) step();
        checks++;
        if ({b16.busy, b16.done, b16.ovf, b16.count} !== 19'd0 || {b4.busy, b4.done, b4.ovf, b4.count} !== 7'd0) begin
            errors++;
            $display("FAIL reset_values got16=%0h got4=%0h want=0",
                     {b16.busy, b16.done, b16.ovf, b16.count}, {b4.busy, b4.done, b4.ovf, b4.count});
        end
        @(negedge clk) rn = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        int nb;
        run(16, 133, 1, 136, 1'b1, -1, -1, nb);
        chk_int("busy_133", nb, 133);
        chk_drained("prior_0x42");
        checks++;
        if (b16.count !== 16'h0042) begin
            errors++;
            $display("FAIL prior_count got=%0h want=42", b16.count);
        end
        run(16, 100, 1, 20, 1'b0, -1, -1, nb);
        #2 rn = 1'b0;
        #1;
        checks++;
        if ({b16.busy, b16.done, b16.ovf, b16.count} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset got=%0h want=0", {b16.busy, b16.done, b16.ovf, b16.count});
        end
        last16_cnt = 0;
        last16_ovf = 0;
        @(negedge clk) rn = 1'b1;
        repeat (120) step();
        chk_int("busy_after_reset", int'(b16.busy), 0);
    endtask

    task automatic test_exact_count();
        int nb;
        run(16, 100, 0, 105, 1'b1, -1, -1, nb);
        chk_int("busy_100", nb, 100);
        chk_drained("exact_count");
        flush();
    endtask

    task automatic test_idle_osc();
        int nb;
        ro = 1'b1;
        repeat (6) step();
        run(16, 50, 2, 55, 1'b1, -1, -1, nb);
        chk_drained("idle_osc");
        flush();
    endtask

    task automatic test_saturation();
        int nb;
        run(4, 64, 1, 70, 1'b1, -1, -1, nb);
        chk_int("busy_sat", nb, 64);
        chk_drained("saturation");
        flush();
    endtask

    task automatic test_win_zero();
        int nb;
        run(16, 0, 0, 5, 1'b1, -1, -1, nb);
        chk_int("busy_w0", nb, 0);
        chk_drained("win_zero");
    endtask

    task automatic test_back_to_back();
        int nb;
        run(16, 8, 0, 8, 1'b1, -1, -1, nb);
        chk_int("busy_b2b_first", nb, 8);
        run(16, 8, 0, 12, 1'b1, -1, -1, nb);
        chk_int("busy_b2b_second", nb, 8);
        chk_drained("back_to_back");
    endtask

    task automatic test_start_during();
        int nb;
        run(16, 40, 0, 45, 1'b1, 20, -1, nb);
        chk_int("busy_start_during", nb, 40);
        chk_drained("start_during");
        flush();
    endtask

    task automatic test_abort();
        int nb, pc, po;
        pc = last16_cnt;
        po = last16_ovf;
        run(16, 100, 1, 110, 1'b0, -1, 30, nb);
        chk_int("busy_abort", nb, 30);
        chk_int("abort_count_kept", int'(b16.count), pc);
        chk_int("abort_ovf_kept", int'(b16.ovf), po);
        b16.en = 1'b1;
        flush();
        run(16, 20, 1, 25, 1'b1, -1, -1, nb);
        chk_int("busy_after_abort", nb, 20);
        chk_drained("after_abort");
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_exact_count();
        test_idle_osc();
        test_saturation();
        test_win_zero();
        test_back_to_back();
        test_start_during();
        test_abort();
        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
